// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - per-bit synchronizer and stability-count debouncer with edge strobes
module button_debouncer #(
    parameter int WIDTH         = 5,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] db_nx;
    logic [WIDTH-1:0] rise_nx;
    logic [WIDTH-1:0] fall_nx;
    logic [CNT_W-1:0] cnt    [WIDTH];
    logic [CNT_W-1:0] cnt_nx [WIDTH];

    // Any cycle where s2 agrees with db restarts the count, so only an
    // unbroken run of STABLE_CYCLES disagreeing samples moves db.
    always_comb begin
        db_nx   = db;
        rise_nx = '0;
        fall_nx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nx[i] = '0;
            if (s2[i] != db[i]) begin
                if (cnt[i] >= LAST) begin
                    db_nx[i]   = s2[i];
                    rise_nx[i] = s2[i];
                    fall_nx[i] = ~s2[i];
                end else begin
                    cnt_nx[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= '0;
            s2      <= '0;
            db      <= '0;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1      <= raw;
            s2      <= s1;
            db      <= db_nx;
            rise    <= rise_nx;
            fall    <= fall_nx;
            changed <= |(rise_nx | fall_nx);
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nx[i];
            end
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer with STABLE_CYCLES=4
module tb_button_debouncer;

    localparam int W = 5;
    localparam int S = 4;

    typedef struct {
        int         at;
        logic [4:0] d;
        logic [4:0] r;
        logic [4:0] f;
    } ev_t;

    logic         clk;
    logic         reset;
    logic [W-1:0] raw;
    logic [W-1:0] db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    ev_t  sb_q[$];
    logic [4:0] exp_db = '0;

    button_debouncer #(.WIDTH(W), .STABLE_CYCLES(S), .CNT_W(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw),
        .db     (db),
        .rise   (rise),
        .fall   (fall),
        .changed(changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
    endtask

    task automatic push(input int at, input logic [4:0] d, input logic [4:0] r, input logic [4:0] f);
        ev_t e;
        e.at = at;
        e.d  = d;
        e.r  = r;
        e.f  = f;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Outside scheduled events db holds its last expected level and no strobe may fire.
    always @(negedge clk) begin
        logic [4:0] er;
        logic [4:0] ef;
        ev_t        e;
        if (cyc >= 1) begin
            er = '0;
            ef = '0;
            if (sb_q.size() > 0 && sb_q[0].at == cyc) begin
                e      = sb_q.pop_front();
                exp_db = e.d;
                er     = e.r;
                ef     = e.f;
            end
            check("db", 32'(db), 32'(exp_db));
            check("rise", 32'(rise), 32'(er));
            check("fall", 32'(fall), 32'(ef));
            check("changed", 32'(changed), 32'(|(er | ef)));
        end
    end

    initial begin
        logic [5:0] pat;
        reset = 1'b1;
        raw   = 5'b11111;
        push(1, 5'b00000, 5'b00000, 5'b00000);
        repeat (3) step();

        // Held-high inputs debounce from scratch once reset is released.
        reset = 1'b0;
        push(cyc + S + 2, 5'b11111, 5'b11111, 5'b00000);
        repeat (10) step();

        raw = 5'b00101;
        push(cyc + S + 2, 5'b00101, 5'b00000, 5'b11010);
        repeat (10) step();

        raw = 5'b00000;
        push(cyc + S + 2, 5'b00000, 5'b00000, 5'b00101);
        repeat (10) step();

        raw = 5'b10000;
        push(cyc + S + 2, 5'b10000, 5'b10000, 5'b00000);
        repeat (10) step();

        // Bounce train 1,0,1,1,0,1 then held high; only the final run counts.
        pat = 6'b101101;
        for (int k = 0; k < 6; k++) begin
            raw[0] = pat[k];
            if (k == 5) push(cyc + S + 2, 5'b10001, 5'b00001, 5'b00000);
            step();
        end
        repeat (10) step();

        raw[1] = 1'b1;
        push(cyc + S + 2, 5'b10011, 5'b00010, 5'b00000);
        repeat (2) step();
        raw[3] = 1'b1;
        push(cyc + S + 2, 5'b11011, 5'b01000, 5'b00000);
        repeat (10) step();

        // Reset lands while bit 2 is mid-count: no pulse, everything re-debounces.
        raw[2] = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        push(cyc + 1, 5'b00000, 5'b00000, 5'b00000);
        step();
        reset = 1'b0;
        push(cyc + S + 2, 5'b11111, 5'b11111, 5'b00000);
        repeat (10) step();

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions the raw board switch/button inputs before they reach the data memory's memory-mapped input port, which exposes the 4-bit value and its flag.
- Per bit: 2-flop synchronizer, then a stability counter.
- Outputs a clean debounced level per bit, plus one-cycle rise/fall strobes and an any-change strobe, so software and the LED mirror see no bounce.
- One instance covers the flag button and the 4 value switches (WIDTH=5).

Parameters:
- WIDTH, 5, number of independent input bits (bit 4 = flag button, bits 3:0 = value switches).
- STABLE_CYCLES, 50000, consecutive clk cycles a synchronized input must differ from the debounced level before the level changes (1 ms at 50 MHz); legal range 1..2^CNT_W-1.
- CNT_W, 16, counter width per bit.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- raw  input  WIDTH  asynchronous switch/button levels from pins.
- db  output  WIDTH  debounced level, registered.
- rise  output  WIDTH  one-cycle pulse when db bit goes 0->1.
- fall  output  WIDTH  one-cycle pulse when db bit goes 1->0.
- changed  output  1  OR of rise|fall, same cycle.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-high.
- Reset (sampled high at a rising edge) clears: sync flops s1,s2, all counters, db, rise, fall, changed -> 0. Reset has priority over everything.
- Reset mid-count: the count is discarded and db returns to 0 even if raw is held high. A held-high bit then re-debounces and produces a rise pulse after the full latency.
- Synchronizer: s1<=raw, s2<=s1 every edge. Only s2 feeds logic; raw is never used combinationally.
- Per-bit counter (cnt[i], CNT_W bits), evaluated each edge when not in reset:
  - s2[i]==db[i]: cnt<=0, no pulse.
  - s2[i]!=db[i] and cnt<STABLE_CYCLES-1: cnt<=cnt+1.
  - s2[i]!=db[i] and cnt==STABLE_CYCLES-1: db[i]<=s2[i], cnt<=0. rise[i] (if s2=1) or fall[i] (if s2=0) is asserted for exactly the cycle in which db has its new value.
- Glitch rejection: any single cycle where s2[i] returns to db[i] zeroes cnt[i]. A bounce train is filtered unless one level persists STABLE_CYCLES cycles.
- Latency: raw changes before edge E1 and stays stable -> db updates at edge E(STABLE_CYCLES+2), counting the first sampling edge as E1 (2 sync edges + STABLE_CYCLES count edges).
- rise/fall/changed are registered: high for one cycle only, never two consecutive cycles for the same bit. rise[i] and fall[i] are never high together.
- Bits are fully independent. Simultaneous transitions on several bits each produce their own pulse. changed is high if any bit pulses.
- Counter never wraps: it is held at or below STABLE_CYCLES-1 by construction. No saturation logic is needed beyond the compare.
- STABLE_CYCLES=1: db follows s2 with one extra cycle (3-edge latency total); no filtering.
- Outputs db/rise/fall/changed come directly from flops, with no combinational path from raw.

Test Plan:
- Reset: STABLE_CYCLES=4; raw=5'b11111 held during reset for 3 edges -> db=0, rise=fall=0, changed=0 throughout reset. After reset deasserts, db=5'b11111 at the 6th edge, with rise=5'b11111 and changed=1 for exactly that cycle.
- Clean press: STABLE_CYCLES=4, raw[4] 0->1 before E1 and held -> db[4]=1 at E6; rise[4]=1 only in cycle after E6; db[3:0] unchanged, fall=0.
- Bounce: STABLE_CYCLES=4, raw[0] pattern 1,0,1,1,0,1,1,1,1,1… (one value per cycle) -> db[0] rises only after 4 consecutive synchronized 1s, i.e. 6 edges after the final 0->1 transition. No pulse before that, and exactly one rise pulse.
- Release: from db=5'b00101, raw=5'b00000 held -> fall=5'b00101 in one cycle at E6, db=0, changed=1 for one cycle; rise stays 0.
- Simultaneous and independent: raw[1] rises at E1 and raw[3] rises at E3 -> rise[1] pulses at E6 and rise[3] pulses at E8. changed pulses in both cycles.
- Reset mid-count: raw[2]=1 held, reset asserted at E4 (counter at 2) -> db[2]=0, no pulse. After release, rise[2] appears 6 edges after reset deasserts.
